// File: rtl/tdm_tx.sv
// tdm_tx: slave TDM/I2S serial transmitter with double-buffered frame staging.
// Build option TDM_TX_UNDERRUN_REPEAT_EN: repeat the previous frame on underrun instead of silence.

module tdm_tx_slot_fmt #(
  parameter int SLOT_WIDTH   = 32,
  parameter int SAMPLE_WIDTH = 24
) (
  input  logic                    mode_in,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  output logic [SLOT_WIDTH-1:0]   slot_out
);
  localparam int PAD = SLOT_WIDTH - SAMPLE_WIDTH;

  logic [SLOT_WIDTH-1:0] msb_j, lsb_j;

  assign msb_j    = SLOT_WIDTH'(sample_in) << PAD;
  assign lsb_j    = SLOT_WIDTH'($signed(sample_in));
  assign slot_out = mode_in ? lsb_j : msb_j;
endmodule

module tdm_tx #(
  parameter int NUM_CH       = 2,
  parameter int SLOT_WIDTH   = 32,
  parameter int SAMPLE_WIDTH = 24
) (
  input  logic                     arstn_in,
  input  logic                     sclk_in,
  input  logic                     fs_in,
  input  logic                     mode_in,
  input  logic [SAMPLE_WIDTH-1:0]  s_data_in,
  input  logic                     s_valid_in,
  output logic                     s_ready_out,
  output logic                     sdata_out,
  output logic                     underrun_out,
  output logic [$clog2(NUM_CH):0]  slot_out
);
  localparam int CW = $clog2(NUM_CH) + 1;
  localparam int BW = $clog2(SLOT_WIDTH);
  localparam logic [CW-1:0] SLOT_IDLE = CW'(NUM_CH);
  localparam logic [CW-1:0] SLOT_LAST = CW'(NUM_CH - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(SLOT_WIDTH - 1);

  logic                                fs_d1_q, fs_d2_q, fs_start, fs_fall;
  logic [NUM_CH-1:0][SAMPLE_WIDTH-1:0] stg_q, stg_d, act_q, act_d;
  logic [CW-1:0]                       wr_ptr_q, wr_ptr_d;
  logic                                mode_q, mode_d, underrun_q, underrun_d;
  logic                                full;
  logic [NUM_CH-1:0][SLOT_WIDTH-1:0]   fmt;
  logic [SLOT_WIDTH-1:0]               sh_q, sh_d, fmt_next;
  logic [BW-1:0]                       bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]                       slot_cnt_q, slot_cnt_d;

  // fs_fall is the next-cycle value of fs_start, so the swap lands on the
  // same posedge that raises fs_start and the new frame is ready for the negedge.
  assign fs_fall  = fs_d1_q & ~fs_in;
  assign fs_start = fs_d2_q & ~fs_d1_q;
  assign full     = (wr_ptr_q == SLOT_IDLE);

  always_comb begin
    stg_d      = stg_q;
    wr_ptr_d   = wr_ptr_q;
    act_d      = act_q;
    mode_d     = mode_q;
    underrun_d = 1'b0;
    if (fs_fall) begin
      wr_ptr_d = '0;
      mode_d   = mode_in;
      if (full) begin
        act_d = stg_q;
      end else begin
        underrun_d = 1'b1;
`ifdef TDM_TX_UNDERRUN_REPEAT_EN
        act_d = act_q;
`else
        act_d = '0;
`endif
      end
    end else if (s_valid_in && !full) begin
      for (int i = 0; i < NUM_CH; i++)
        if (wr_ptr_q == CW'(i)) stg_d[i] = s_data_in;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge sclk_in or negedge arstn_in) begin
    if (!arstn_in) begin
      fs_d1_q    <= 1'b0;
      fs_d2_q    <= 1'b0;
      stg_q      <= '0;
      wr_ptr_q   <= '0;
      act_q      <= '0;
      mode_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      fs_d1_q    <= fs_in;
      fs_d2_q    <= fs_d1_q;
      stg_q      <= stg_d;
      wr_ptr_q   <= wr_ptr_d;
      act_q      <= act_d;
      mode_q     <= mode_d;
      underrun_q <= underrun_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_fmt
    tdm_tx_slot_fmt #(
      .SLOT_WIDTH  (SLOT_WIDTH),
      .SAMPLE_WIDTH(SAMPLE_WIDTH)
    ) u_fmt (
      .mode_in  (mode_q),
      .sample_in(act_q[g]),
      .slot_out (fmt[g])
    );
  end

  always_comb begin
    fmt_next = '0;
    for (int i = 1; i < NUM_CH; i++)
      if (slot_cnt_q == CW'(i - 1)) fmt_next = fmt[i];
  end

  // Frame sync always wins, so an early frame truncates the current slot.
  always_comb begin
    sh_d       = {sh_q[SLOT_WIDTH-2:0], 1'b0};
    bit_cnt_d  = (bit_cnt_q == BIT_LAST) ? bit_cnt_q : bit_cnt_q + 1'b1;
    slot_cnt_d = slot_cnt_q;
    if (fs_start) begin
      sh_d       = fmt[0];
      bit_cnt_d  = '0;
      slot_cnt_d = '0;
    end else if (bit_cnt_q == BIT_LAST && slot_cnt_q < SLOT_LAST) begin
      sh_d       = fmt_next;
      bit_cnt_d  = '0;
      slot_cnt_d = slot_cnt_q + 1'b1;
    end else if (bit_cnt_q == BIT_LAST && slot_cnt_q == SLOT_LAST) begin
      sh_d       = '0;
      slot_cnt_d = SLOT_IDLE;
    end
  end

  always_ff @(negedge sclk_in or negedge arstn_in) begin
    if (!arstn_in) begin
      sh_q       <= '0;
      bit_cnt_q  <= '0;
      slot_cnt_q <= SLOT_IDLE;
    end else begin
      sh_q       <= sh_d;
      bit_cnt_q  <= bit_cnt_d;
      slot_cnt_q <= slot_cnt_d;
    end
  end

  assign s_ready_out  = ~full;
  assign sdata_out    = sh_q[SLOT_WIDTH-1];
  assign underrun_out = underrun_q;
  assign slot_out     = slot_cnt_q;
endmodule

// File: tb/tb_tdm_tx.sv
// Bench for tdm_tx: per-cycle scoreboard fed by a frame-level reference model.
module tb_tdm_tx;
  localparam int NCH = 2, SW = 32, SAM = 24;
  localparam int CW = $clog2(NCH) + 1;
  localparam int IDLE_T = NCH * SW;
  localparam longint MASK = (64'sd1 <<< SAM) - 1;

  logic arstn_in = 1'b0, sclk_in = 1'b0, fs_in = 1'b1, mode_in = 1'b0, s_valid_in = 1'b0;
  logic [SAM-1:0] s_data_in = '0;
  logic s_ready_out, sdata_out, underrun_out;
  logic [CW-1:0] slot_out;

  tdm_tx #(.NUM_CH(NCH), .SLOT_WIDTH(SW), .SAMPLE_WIDTH(SAM)) dut (
    .arstn_in(arstn_in), .sclk_in(sclk_in), .fs_in(fs_in), .mode_in(mode_in),
    .s_data_in(s_data_in), .s_valid_in(s_valid_in), .s_ready_out(s_ready_out),
    .sdata_out(sdata_out), .underrun_out(underrun_out), .slot_out(slot_out)
  );

  always #5 sclk_in = ~sclk_in;

  typedef struct { bit sd; int slot; bit ur; bit rdy; } exp_t;
  exp_t exp_q[$];
  int n_cmp = 0, n_bad = 0;

  // reference model state
  longint stg[$];
  longint pend[$];
  longint act[NCH];
  bit m_mode = 0, m_ur = 0, prev_fs = 0, swap_prev = 0, in_rst = 1;
  int t = IDLE_T;

  task automatic chk(string nm, longint got, longint want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
    end
  endtask

  // bit b (0 = first sent) of a sample placed in its slot
  function automatic bit slot_bit(longint smp, bit md, int b);
    longint v, sv;
    if (!md) v = smp * (64'sd1 <<< (SW - SAM));
    else begin
      sv = (smp >= (64'sd1 <<< (SAM - 1))) ? smp - (64'sd1 <<< SAM) : smp;
      v  = (sv < 0) ? sv + (64'sd1 <<< SW) : sv;
    end
    return v[SW-1-b];
  endfunction

  task automatic cycle(bit fs, bit md, bit rst_on, bit rst_off);
    bit valid, swap, acc;
    longint d;
    int s;
    exp_t e;
    @(negedge sclk_in);
    if (!in_rst) begin
      if (swap_prev) t = 0;
      else if (t < IDLE_T) t++;
    end
    if (rst_on) begin
      #2 arstn_in = 1'b0;
      #1;
      chk("rst_sdata", sdata_out, 0);
      chk("rst_ready", s_ready_out, 1);
      chk("rst_slot", slot_out, NCH);
      chk("rst_underrun", underrun_out, 0);
      in_rst = 1;
      pend.delete();
    end
    if (rst_off) begin
      #2 arstn_in = 1'b1;
      in_rst = 0;
    end
    if (in_rst) begin
      t = IDLE_T; stg.delete(); m_mode = 0; m_ur = 0; prev_fs = 0; swap_prev = 0;
      foreach (act[i]) act[i] = 0;
      s_valid_in = 1'b0; fs_in = fs; mode_in = md;
    end
    s = t / SW;
    e.slot = (s < NCH) ? s : NCH;
    e.sd   = (s < NCH) ? slot_bit(act[s], m_mode, t % SW) : 1'b0;
    if (!in_rst) begin
      valid = 0;
      d = longint'($urandom) & MASK;
      if (pend.size() > 0 && $urandom_range(0, 3) != 0) begin
        valid = 1; d = pend[0];
      end else if (stg.size() == NCH && $urandom_range(0, 1) == 1) valid = 1;
      acc = valid && (stg.size() < NCH);
      if (acc) void'(pend.pop_front());
      fs_in = fs; mode_in = md; s_valid_in = valid; s_data_in = SAM'(d);
      swap = prev_fs && !fs;
      m_ur = 0;
      if (swap) begin
        if (stg.size() == NCH) foreach (act[i]) act[i] = stg[i];
        else begin
          m_ur = 1;
`ifndef TDM_TX_UNDERRUN_REPEAT_EN
          foreach (act[i]) act[i] = 0;
`endif
        end
        stg.delete();
        m_mode = md;
      end else if (acc) stg.push_back(d);
      prev_fs = fs;
      swap_prev = swap;
    end
    e.ur  = m_ur;
    e.rdy = (stg.size() < NCH);
    exp_q.push_back(e);
  endtask

  // fs low for the first half of the frame; its falling edge starts the frame
  task automatic frame(int len, bit md, int nsamp, int rst_at);
    bit f, m;
    for (int i = 0; i < nsamp; i++) pend.push_back(longint'($urandom) & MASK);
    for (int c = 0; c < len; c++) begin
      f = (c >= len / 2);
      m = (c == 0) ? md : 1'($urandom_range(0, 1));
      cycle(f, m, rst_at >= 0 && c == rst_at, rst_at >= 0 && c == rst_at + 3);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge sclk_in);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sdata", sdata_out, e.sd);
        chk("slot", slot_out, e.slot);
        chk("underrun", underrun_out, e.ur);
        chk("ready", s_ready_out, e.rdy);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int len, ns;
    bit md;
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 1);
    pend.push_back(64'hABCDEF);
    pend.push_back(64'h123456);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0);
    pend.push_back(64'h800001);
    pend.push_back(64'h000002);
    frame(64, 0, 0, -1);        // ABCDEF00 / 12345600
    pend.push_back(64'h5A5A5A); // only one sample staged -> next frame underruns
    frame(64, 1, 0, -1);        // FF800001 / 00000002
    frame(64, 0, 2, -1);        // underrun frame
    frame(40, 0, 2, -1);        // short frame truncates slot 1
    frame(80, 1, 2, -1);        // long frame pads 16 zeros
    frame(64, 0, 2, -1);
    for (int k = 0; k < 24; k++) begin
      len = $urandom_range(40, 96);
      md  = 1'($urandom_range(0, 1));
      ns  = ($urandom_range(0, 5) == 0) ? 1 : 2;
      frame(len, md, ns, -1);
    end
    frame(64, 0, 0, 40);        // reset mid slot 1
    frame(64, 0, 2, -1);        // underruns after reset
    frame(64, 1, 2, -1);
    frame(64, 0, 0, -1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
    @(posedge sclk_in);
    #2;
    chk("drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
